// File: rtl/fp16_pkg.sv
// Shared widths, bit positions and FSM state type for the binary16
// normalize/round post-add stage.
package fp16_pkg;

    localparam int EXP_W      = 5;
    localparam int FRAC_W     = 10;
    localparam int MANT_EXT_W = 14;
    localparam int MANT_SUM_W = 15;

    // Internal exponent is one bit wider so a carry past 30 is still visible.
    localparam logic [EXP_W:0] EXP_MAX = 6'd31;

    // Bit positions inside the 15-bit extended mantissa sum.
    localparam int CARRY_BIT  = 14;
    localparam int HIDDEN_BIT = 13;
    localparam int LSB_BIT    = 3;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_rne_round.sv
// Combinational round-to-nearest-even and binary16 packing.
// Input mantissa is already normalized (bit 14 clear); a clear hidden bit
// with a nonzero mantissa means the value is subnormal (exponent at floor 1).
// Build option: FP16_NORM_SUBNORMAL_EN keeps subnormal results; when it is
// not defined, results whose exponent field ends up 0 are flushed to zero.
module fp16_rne_round
    import fp16_pkg::*;
(
    input  logic [MANT_SUM_W-1:0] i_mant,
    input  logic [EXP_W:0]        i_exp,
    input  logic                  i_sign,
    output logic [15:0]           o_result,
    output logic                  o_overflow,
    output logic                  o_inexact
);

`ifdef FP16_NORM_SUBNORMAL_EN
    localparam bit FTZ = 1'b0;
`else
    localparam bit FTZ = 1'b1;
`endif

    // Round half to even: bump only above half, or at exactly half with odd lsb.
    function automatic logic rne_inc(input logic lsb, input logic g,
                                     input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic              w_zero;
    logic              w_inc;
    logic              w_grs;
    logic [FRAC_W+1:0] w_sum;
    logic [EXP_W:0]    w_exp_f;
    logic [FRAC_W-1:0] w_frac;

    assign w_zero = (i_mant == '0);
    assign w_grs  = i_mant[GUARD_BIT] | i_mant[ROUND_BIT] | i_mant[STICKY_BIT];
    assign w_inc  = rne_inc(i_mant[LSB_BIT], i_mant[GUARD_BIT],
                            i_mant[ROUND_BIT], i_mant[STICKY_BIT]);
    // w_sum[11] = carry out of hidden, w_sum[10] = hidden, w_sum[9:0] = fraction
    assign w_sum  = {1'b0, i_mant[HIDDEN_BIT:LSB_BIT]} + {{(FRAC_W+1){1'b0}}, w_inc};

    // Resolve post-rounding exponent/fraction, then apply the packing rules.
    always_comb begin
        w_exp_f = i_exp;
        w_frac  = w_sum[FRAC_W-1:0];
        if (i_mant[HIDDEN_BIT]) begin
            if (w_sum[FRAC_W+1]) begin
                w_exp_f = i_exp + 6'd1;
                w_frac  = w_sum[FRAC_W:1];
            end
        end else begin
            // Subnormal: a carry into the hidden position makes it the smallest normal.
            w_exp_f = w_sum[FRAC_W] ? 6'd1 : 6'd0;
        end

        o_overflow = 1'b0;
        o_inexact  = w_grs;
        o_result   = {i_sign, w_exp_f[EXP_W-1:0], w_frac};
        if (w_zero) begin
            // Exact cancellation always yields +0.
            o_result  = 16'h0000;
            o_inexact = 1'b0;
        end else if (w_exp_f >= EXP_MAX) begin
            o_result   = {i_sign, 5'h1F, 10'h000};
            o_overflow = 1'b1;
        end else if (FTZ && (w_exp_f == '0)) begin
            o_result  = {i_sign, 15'h0000};
            o_inexact = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_norm_round.sv
// Post-add normalize/round stage of the binary16 adder. Normalizes the raw
// mantissa sum one shift per cycle, rounds to nearest-even and packs the
// result, with valid/ready handshakes upstream and downstream.
// Build option: FP16_NORM_SUBNORMAL_EN (see fp16_rne_round) selects
// subnormal output instead of flush-to-zero.
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic                  IN_CLK,
    input  logic                  IN_RST_N,
    input  logic                  IN_VALID,
    output logic                  OUT_READY,
    input  logic [MANT_SUM_W-1:0] IN_MANT_SUM,
    input  logic [EXP_W-1:0]      IN_EXP,
    input  logic                  IN_SIGN,
    output logic                  OUT_VALID,
    input  logic                  IN_READY,
    output logic [15:0]           OUT_RESULT,
    output logic                  OUT_OVERFLOW,
    output logic                  OUT_INEXACT
);

    state_t                r_state;
    logic                  r_ready;
    logic                  r_valid;
    logic [15:0]           r_result;
    logic                  r_overflow;
    logic                  r_inexact;

    logic [MANT_SUM_W-1:0] r_mant;
    logic [EXP_W:0]        r_exp;
    logic                  r_sign;

    logic [15:0]           w_rnd_result;
    logic                  w_rnd_overflow;
    logic                  w_rnd_inexact;
    logic                  w_accept;
    logic                  w_norm_done;

    assign w_accept    = IN_VALID && r_ready;
    // Normalization stops on zero, on a set hidden bit (with no carry) or at the exponent floor.
    assign w_norm_done = (r_mant == '0) ||
                         (!r_mant[CARRY_BIT] && (r_mant[HIDDEN_BIT] || (r_exp <= 6'd1)));

    fp16_rne_round u_rne_round (
        .i_mant     (r_mant),
        .i_exp      (r_exp),
        .i_sign     (r_sign),
        .o_result   (w_rnd_result),
        .o_overflow (w_rnd_overflow),
        .o_inexact  (w_rnd_inexact)
    );

    // Control FSM and registered handshake/result outputs.
    always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
        if (!IN_RST_N) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_result   <= 16'h0000;
            r_overflow <= 1'b0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (w_norm_done) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_result   <= w_rnd_result;
                    r_overflow <= w_rnd_overflow;
                    r_inexact  <= w_rnd_inexact;
                    r_valid    <= 1'b1;
                    r_state    <= DONE;
                end
                DONE: begin
                    if (IN_READY) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on accept and one normalization shift per NORM cycle.
    always_ff @(posedge IN_CLK) begin
        if (r_state == IDLE) begin
            if (w_accept) begin
                r_mant <= IN_MANT_SUM;
                r_exp  <= {1'b0, IN_EXP};
                r_sign <= IN_SIGN;
            end
        end else if (r_state == NORM && !w_norm_done) begin
            if (r_mant[CARRY_BIT]) begin
                // Carry: shift right, keep the dropped bit alive in sticky.
                r_mant <= {1'b0, r_mant[CARRY_BIT:GUARD_BIT],
                           r_mant[ROUND_BIT] | r_mant[STICKY_BIT]};
                r_exp  <= r_exp + 6'd1;
            end else begin
                r_mant <= {r_mant[MANT_SUM_W-2:0], 1'b0};
                r_exp  <= r_exp - 6'd1;
            end
        end
    end

    assign OUT_READY    = r_ready;
    assign OUT_VALID    = r_valid;
    assign OUT_RESULT   = r_result;
    assign OUT_OVERFLOW = r_overflow;
    assign OUT_INEXACT  = r_inexact;

endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed, table-driven bench for fp16_norm_round: result, flags and
// latency per vector, plus backpressure and mid-operation reset sequences.
module tb_fp16_norm_round;

    logic        IN_CLK = 1'b0;
    logic        IN_RST_N;
    logic        IN_VALID;
    logic        OUT_READY;
    logic [14:0] IN_MANT_SUM;
    logic [4:0]  IN_EXP;
    logic        IN_SIGN;
    logic        OUT_VALID;
    logic        IN_READY;
    logic [15:0] OUT_RESULT;
    logic        OUT_OVERFLOW;
    logic        OUT_INEXACT;

    always #5 IN_CLK = ~IN_CLK;

    fp16_norm_round dut (
        .IN_CLK       (IN_CLK),
        .IN_RST_N     (IN_RST_N),
        .IN_VALID     (IN_VALID),
        .OUT_READY    (OUT_READY),
        .IN_MANT_SUM  (IN_MANT_SUM),
        .IN_EXP       (IN_EXP),
        .IN_SIGN      (IN_SIGN),
        .OUT_VALID    (OUT_VALID),
        .IN_READY     (IN_READY),
        .OUT_RESULT   (OUT_RESULT),
        .OUT_OVERFLOW (OUT_OVERFLOW),
        .OUT_INEXACT  (OUT_INEXACT)
    );

    typedef struct packed {
        logic [14:0] mant;
        logic [4:0]  exp;
        logic        sign;
        logic [15:0] res;
        logic        ovf;
        logic        inx;
        logic [4:0]  lat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Wait (bounded) for OUT_VALID after an accept edge; returns edges counted.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!OUT_VALID && lat < 40) begin
            @(posedge IN_CLK);
            #1;
            lat++;
        end
    endtask

    // Present one operand set for exactly one accept edge, then scramble inputs.
    task automatic offer(input vec_t v);
        @(negedge IN_CLK);
        IN_VALID    = 1'b1;
        IN_MANT_SUM = v.mant;
        IN_EXP      = v.exp;
        IN_SIGN     = v.sign;
        @(posedge IN_CLK);
        #1;
        IN_VALID    = 1'b0;
        IN_MANT_SUM = ~v.mant;
        IN_EXP      = ~v.exp;
        IN_SIGN     = ~v.sign;
    endtask

    task automatic run_vec(input int idx);
        int lat;
        vec_t v;
        v = vecs[idx];
        offer(v);
        check($sformatf("vec%0d busy", idx), {31'd0, OUT_READY}, 32'd0);
        wait_valid(lat);
        check($sformatf("vec%0d latency", idx), lat, {27'd0, v.lat});
        check($sformatf("vec%0d result", idx), {16'd0, OUT_RESULT}, {16'd0, v.res});
        check($sformatf("vec%0d overflow", idx), {31'd0, OUT_OVERFLOW}, {31'd0, v.ovf});
        check($sformatf("vec%0d inexact", idx), {31'd0, OUT_INEXACT}, {31'd0, v.inx});
        @(posedge IN_CLK);
        #1;
        check($sformatf("vec%0d release", idx), {30'd0, OUT_VALID, OUT_READY}, 32'd1);
    endtask

    initial begin
        int lat;

        //                mant      exp    s   result    ovf   inx   lat
        vecs[0]  = '{15'h2000, 5'd15, 1'b0, 16'h3C00, 1'b0, 1'b0, 5'd2};
        vecs[1]  = '{15'h4000, 5'd15, 1'b0, 16'h4000, 1'b0, 1'b0, 5'd3};
        vecs[2]  = '{15'h4000, 5'd30, 1'b0, 16'h7C00, 1'b1, 1'b0, 5'd3};
        vecs[3]  = '{15'h2004, 5'd15, 1'b0, 16'h3C00, 1'b0, 1'b1, 5'd2};
        vecs[4]  = '{15'h200C, 5'd15, 1'b0, 16'h3C02, 1'b0, 1'b1, 5'd2};
        vecs[5]  = '{15'h0400, 5'd15, 1'b0, 16'h3000, 1'b0, 1'b0, 5'd5};
        vecs[6]  = '{15'h0000, 5'd15, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd2};
`ifdef FP16_NORM_SUBNORMAL_EN
        vecs[7]  = '{15'h0800, 5'd2,  1'b0, 16'h0200, 1'b0, 1'b0, 5'd3};
        vecs[8]  = '{15'h0001, 5'd5,  1'b0, 16'h0002, 1'b0, 1'b0, 5'd6};
`else
        vecs[7]  = '{15'h0800, 5'd2,  1'b0, 16'h0000, 1'b0, 1'b1, 5'd3};
        vecs[8]  = '{15'h0001, 5'd5,  1'b0, 16'h0000, 1'b0, 1'b1, 5'd6};
`endif
        vecs[9]  = '{15'h3FFC, 5'd30, 1'b0, 16'h7C00, 1'b1, 1'b1, 5'd2};
        vecs[10] = '{15'h4003, 5'd15, 1'b1, 16'hC000, 1'b0, 1'b1, 5'd3};
        vecs[11] = '{15'h0001, 5'd20, 1'b0, 16'h1C00, 1'b0, 1'b0, 5'd15};
        vecs[12] = '{15'h1FFC, 5'd1,  1'b0, 16'h0400, 1'b0, 1'b1, 5'd2};
        vecs[13] = '{15'h5FFE, 5'd15, 1'b0, 16'h4200, 1'b0, 1'b1, 5'd3};

        IN_RST_N    = 1'b0;
        IN_VALID    = 1'b0;
        IN_READY    = 1'b1;
        IN_MANT_SUM = '0;
        IN_EXP      = '0;
        IN_SIGN     = 1'b0;

        #12;
        check("reset valid",    {31'd0, OUT_VALID},    32'd0);
        check("reset ready",    {31'd0, OUT_READY},    32'd1);
        check("reset result",   {16'd0, OUT_RESULT},   32'd0);
        check("reset overflow", {31'd0, OUT_OVERFLOW}, 32'd0);
        check("reset inexact",  {31'd0, OUT_INEXACT},  32'd0);
        @(negedge IN_CLK);
        IN_RST_N = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Backpressure: result must hold and no new accept while DONE.
        IN_READY = 1'b0;
        offer(vecs[0]);
        wait_valid(lat);
        check("bp latency", lat, 32'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge IN_CLK);
            IN_VALID    = 1'b1;
            IN_MANT_SUM = 15'h4000;
            IN_EXP      = 5'd20;
            @(posedge IN_CLK);
            #1;
            check($sformatf("bp%0d result", c), {16'd0, OUT_RESULT}, 32'h3C00);
            check($sformatf("bp%0d valid/ready", c), {30'd0, OUT_VALID, OUT_READY}, 32'd2);
        end
        @(negedge IN_CLK);
        IN_VALID = 1'b0;
        IN_READY = 1'b1;
        @(posedge IN_CLK);
        #1;
        check("bp release", {30'd0, OUT_VALID, OUT_READY}, 32'd1);
        check("bp result held", {16'd0, OUT_RESULT}, 32'h3C00);

        // Reset in the middle of a long normalization.
        offer(vecs[11]);
        repeat (3) @(posedge IN_CLK);
        #1;
        check("midrst busy", {31'd0, OUT_READY}, 32'd0);
        IN_RST_N = 1'b0;
        #1;
        check("midrst valid",    {31'd0, OUT_VALID},    32'd0);
        check("midrst ready",    {31'd0, OUT_READY},    32'd1);
        check("midrst result",   {16'd0, OUT_RESULT},   32'd0);
        check("midrst overflow", {31'd0, OUT_OVERFLOW}, 32'd0);
        check("midrst inexact",  {31'd0, OUT_INEXACT},  32'd0);
        repeat (2) @(posedge IN_CLK);
        #1;
        check("midrst no emit", {31'd0, OUT_VALID}, 32'd0);
        @(negedge IN_CLK);
        IN_RST_N = 1'b1;
        run_vec(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
